// File: rtl/shift_seq_pkg.sv
// Shared encodings for the shift sequencer: command ops, register selects, FSM states.
package shift_seq_pkg;

    typedef enum logic [1:0] {
        OP_SHR = 2'b00,
        OP_SHL = 2'b01,
        OP_ROR = 2'b10,
        OP_ROL = 2'b11
    } op_e;

    typedef enum logic [1:0] {
        SEL_HOLD = 2'b00,
        SEL_SHR  = 2'b01,
        SEL_SHL  = 2'b10,
        SEL_LOAD = 2'b11
    } sel_e;

    typedef enum logic [1:0] {
        IDLE  = 2'b00,
        LOAD  = 2'b01,
        SHIFT = 2'b10,
        DONE  = 2'b11
    } state_e;

    // Right-moving ops (SHR/ROR) use the shift-right select, the rest shift left.
    function automatic sel_e shift_sel(input op_e op);
        return ((op == OP_SHR) || (op == OP_ROR)) ? SEL_SHR : SEL_SHL;
    endfunction

endpackage

// File: rtl/shift_seq_counter.sv
// Down-counter holding the number of shift cycles still to run for the current command.
module shift_seq_counter #(
    parameter int CNT_W = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             load,
    input  logic [CNT_W-1:0] load_val,
    input  logic             dec,
    output logic [CNT_W-1:0] count,
    output logic             last
);

    logic [CNT_W-1:0] cnt;

    // Load on command accept, otherwise count down one per shift cycle without wrapping.
    always_ff @(posedge clk) begin
        if (reset) begin
            cnt <= '0;
        end else if (load) begin
            cnt <= load_val;
        end else if (dec && (cnt != '0)) begin
            cnt <= cnt - 1'b1;
        end
    end

    assign count = cnt;
    assign last  = (cnt == CNT_W'(1));

endmodule

// File: rtl/shift_sequencer.sv
// Command-driven controller for an external universal shift register: one parallel load,
// then 'count' shift/rotate cycles, then the register value is returned with a done pulse.
// Optional feature: define SHIFT_SEQ_ABORT_EN to add the abort input and aborted output.
module shift_sequencer
    import shift_seq_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int CNT_W = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             cmd_valid,
    output logic             cmd_ready,
    input  logic [1:0]       cmd_op,
    input  logic [WIDTH-1:0] cmd_data,
    input  logic [CNT_W-1:0] cmd_count,
    output logic [1:0]       sr_s,
    output logic [WIDTH-1:0] sr_i,
    output logic             sr_r,
    input  logic [WIDTH-1:0] sr_o,
`ifdef SHIFT_SEQ_ABORT_EN
    input  logic             abort,
    output logic             aborted,
`endif
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] result
);

    state_e           state, state_nxt;
    op_e              op_q;
    logic [WIDTH-1:0] data_q;
    logic [WIDTH-1:0] result_q;
    logic             accept;
    logic             cnt_dec;
    logic [CNT_W-1:0] cnt;
    logic             cnt_last;
    logic             abort_hit;
    sel_e             sel;

    assign accept = cmd_valid && cmd_ready;

`ifdef SHIFT_SEQ_ABORT_EN
    assign abort_hit = abort;
`else
    assign abort_hit = 1'b0;
`endif

    shift_seq_counter #(.CNT_W(CNT_W)) u_counter (
        .clk      (clk),
        .reset    (reset),
        .load     (accept),
        .load_val (cmd_count),
        .dec      (cnt_dec),
        .count    (cnt),
        .last     (cnt_last)
    );

    // State, latched command and the result captured from the register in DONE.
    always_ff @(posedge clk) begin
        if (reset) begin
            state    <= IDLE;
            op_q     <= OP_SHR;
            data_q   <= '0;
            result_q <= '0;
        end else begin
            state <= state_nxt;
            if (accept) begin
                op_q   <= op_e'(cmd_op);
                data_q <= cmd_data;
            end
            if (state == DONE) begin
                result_q <= sr_o;
            end
        end
    end

    // Next-state and register drive; an abort holds the register so DONE sees its current value.
    always_comb begin
        state_nxt = state;
        sel       = SEL_HOLD;
        sr_i      = '0;
        sr_r      = 1'b0;
        cnt_dec   = 1'b0;
        case (state)
            IDLE: begin
                if (cmd_valid) state_nxt = LOAD;
            end
            LOAD: begin
                if (abort_hit) begin
                    state_nxt = DONE;
                end else begin
                    sel       = SEL_LOAD;
                    sr_i      = data_q;
                    state_nxt = (cnt == '0) ? DONE : SHIFT;
                end
            end
            SHIFT: begin
                if (abort_hit) begin
                    state_nxt = DONE;
                end else begin
                    sel     = shift_sel(op_q);
                    cnt_dec = 1'b1;
                    if (op_q == OP_ROR) sr_r = sr_o[0];
                    if (op_q == OP_ROL) sr_r = sr_o[WIDTH-1];
                    if (cnt_last) state_nxt = DONE;
                end
            end
            DONE: begin
                state_nxt = IDLE;
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

`ifdef SHIFT_SEQ_ABORT_EN
    logic aborted_q;

    // Remember whether the final LOAD/SHIFT cycle ended because of an abort.
    always_ff @(posedge clk) begin
        if (reset) begin
            aborted_q <= 1'b0;
        end else if ((state == LOAD) || (state == SHIFT)) begin
            aborted_q <= abort_hit;
        end
    end

    assign aborted = done && aborted_q;
`endif

    assign sr_s      = sel;
    assign cmd_ready = (state == IDLE);
    assign busy      = (state != IDLE);
    assign done      = (state == DONE);
    assign result    = done ? sr_o : result_q;

endmodule
